// File: rtl/dsp_pattern_detect.sv
`default_nettype none
// ============================================================================
//  Module      : dsp_pattern_detect
//  Description : Pattern-detect and overflow/underflow stage for the P output
//                register path. Compares the value being loaded into P against
//                a static or dynamic pattern under a mask, and registers the
//                match flags on the P clock enable so they stay aligned with P.
//                Also derives the one-cycle-history flags and the auto-reset
//                request fed back to the P register.
//  Options     : DSP_PD_OVERFLOW_EN - builds the history registers, enabling
//                pd_past/pbd_past, overflow/underflow and AUTORESET = 2.
//                When undefined those outputs are tied low and mode 2 acts
//                as mode 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module dsp_pattern_detect #(
  parameter int                 P_WIDTH     = 48,
  parameter logic [P_WIDTH-1:0] PATTERN     = '0,
  parameter logic [P_WIDTH-1:0] MASK        = 48'h3FFF_FFFF_FFFF,
  parameter int                 SEL_PATTERN = 0,
  parameter int                 AUTORESET   = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  input  logic [P_WIDTH-1:0] p_d,
  input  logic [P_WIDTH-1:0] c,
  output logic               pd,
  output logic               pbd,
  output logic               pd_past,
  output logic               pbd_past,
  output logic               overflow,
  output logic               underflow,
  output logic               auto_rst
);

  // Auto-reset mode; the illegal encoding 3 collapses onto "no reset".
  localparam logic [1:0] c_mode_none      = 2'd0;
  localparam logic [1:0] c_mode_match     = 2'd1;
  localparam logic [1:0] c_mode_not_match = 2'd2;
  localparam logic [1:0] c_autoreset_mode =
      (AUTORESET == 1) ? c_mode_match     :
      (AUTORESET == 2) ? c_mode_not_match : c_mode_none;

  logic [P_WIDTH-1:0] w_pat;
  logic [P_WIDTH-1:0] w_diff;
  logic               w_match;
  logic               w_match_b;
  logic               r_pd;
  logic               r_pbd;
  logic               w_pd_past;
  logic               w_pbd_past;
  logic               w_overflow;
  logic               w_underflow;
  logic               w_rst_on_unmatch;
  logic               w_ar_term;

  // Masked bits are forced to agree, so an all-ones mask matches both ways.
  assign w_pat     = (SEL_PATTERN != 0) ? c : PATTERN;
  assign w_diff    = p_d ^ w_pat;
  assign w_match   = &(~w_diff | MASK);
  assign w_match_b = &( w_diff | MASK);

  // Match flags load alongside P so they describe the value P is showing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pd  <= 1'b0;
      r_pbd <= 1'b0;
    end else if (ce) begin
      r_pd  <= w_match;
      r_pbd <= w_match_b;
    end
  end

`ifdef DSP_PD_OVERFLOW_EN
  logic r_pd_past;
  logic r_pbd_past;

  // One enabled cycle of match history, used to spot leaving a match window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pd_past  <= 1'b0;
      r_pbd_past <= 1'b0;
    end else if (ce) begin
      r_pd_past  <= r_pd;
      r_pbd_past <= r_pbd;
    end
  end

  assign w_pd_past        = r_pd_past;
  assign w_pbd_past       = r_pbd_past;
  assign w_overflow       = r_pd_past  & ~r_pd & ~r_pbd;
  assign w_underflow      = r_pbd_past & ~r_pd & ~r_pbd;
  assign w_rst_on_unmatch = r_pd_past  & ~r_pd;
`else
  assign w_pd_past        = 1'b0;
  assign w_pbd_past       = 1'b0;
  assign w_overflow       = 1'b0;
  assign w_underflow      = 1'b0;
  assign w_rst_on_unmatch = 1'b0;
`endif

  // Select the auto-reset condition for the configured mode.
  always_comb begin
    w_ar_term = 1'b0;
    case (c_autoreset_mode)
      c_mode_match:     w_ar_term = r_pd;
      c_mode_not_match: w_ar_term = w_rst_on_unmatch;
      default:          w_ar_term = 1'b0;
    endcase
  end

  // Gated by ce so P is only cleared on an edge where it would load.
  assign auto_rst  = ce & w_ar_term;

  assign pd        = r_pd;
  assign pbd       = r_pbd;
  assign pd_past   = w_pd_past;
  assign pbd_past  = w_pbd_past;
  assign overflow  = w_overflow;
  assign underflow = w_underflow;

endmodule
`default_nettype wire

// File: tb/tb_dsp_pattern_detect.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dsp_pattern_detect
//  Description : Self-checking bench for dsp_pattern_detect. Four instances
//                with different mask / pattern-select / auto-reset settings
//                share one stimulus stream and are compared every cycle with
//                a behavioural model, plus directed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dsp_pattern_detect;

`ifdef DSP_PD_OVERFLOW_EN
  localparam logic OV_EN = 1'b1;
`else
  localparam logic OV_EN = 1'b0;
`endif

  localparam int N = 4;
  localparam logic [47:0] ONES = {48{1'b1}};

  // Instance configuration: 0 default, 1 low-byte mask + RESET_MATCH,
  // 2 dynamic pattern + RESET_NOT_MATCH, 3 fully masked + illegal mode.
  function automatic logic [47:0] f_mask(int i);
    case (i)
      1:       return 48'hFFFF_FFFF_FF00;
      3:       return {48{1'b1}};
      default: return 48'h3FFF_FFFF_FFFF;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce  = 1'b1;
  logic [47:0] p_d = '0;
  logic [47:0] c   = '0;

  logic [N-1:0] pd_v, pbd_v, pdp_v, pbdp_v, ov_v, un_v, ar_v;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    dsp_pattern_detect #(
      .P_WIDTH    (48),
      .PATTERN    (48'h0),
      .MASK       (f_mask(g)),
      .SEL_PATTERN((g == 2) ? 1 : 0),
      .AUTORESET  (g)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .ce       (ce),
      .p_d      (p_d),
      .c        (c),
      .pd       (pd_v[g]),
      .pbd      (pbd_v[g]),
      .pd_past  (pdp_v[g]),
      .pbd_past (pbdp_v[g]),
      .overflow (ov_v[g]),
      .underflow(un_v[g]),
      .auto_rst (ar_v[g])
    );
  end

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic m_pd[N], m_pbd[N], m_pdp[N], m_pbdp[N];

  function automatic logic f_eq(input logic [47:0] a, input logic [47:0] b, input logic [47:0] mask);
    return ((a & ~mask) == (b & ~mask));
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      logic [47:0] pat;
      pat = (i == 2) ? c : 48'h0;
      if (!rst) begin
        m_pd[i] <= 1'b0; m_pbd[i] <= 1'b0; m_pdp[i] <= 1'b0; m_pbdp[i] <= 1'b0;
      end else if (ce) begin
        m_pd[i]   <= f_eq(p_d, pat, f_mask(i));
        m_pbd[i]  <= f_eq(~p_d, pat, f_mask(i));
        m_pdp[i]  <= OV_EN & m_pd[i];
        m_pbdp[i] <= OV_EN & m_pbd[i];
      end
    end
  end

  // Compare every cycle, 1 time unit after the edge.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      logic e_ov, e_un, e_ar;
      e_ov = m_pdp[i]  && !m_pd[i] && !m_pbd[i];
      e_un = m_pbdp[i] && !m_pd[i] && !m_pbd[i];
      case (i)
        1:       e_ar = ce && m_pd[i];
        2:       e_ar = ce && m_pdp[i] && !m_pd[i];
        default: e_ar = 1'b0;
      endcase
      chk($sformatf("model u%0d.pd", i),        {47'b0, pd_v[i]},   {47'b0, m_pd[i]});
      chk($sformatf("model u%0d.pbd", i),       {47'b0, pbd_v[i]},  {47'b0, m_pbd[i]});
      chk($sformatf("model u%0d.pd_past", i),   {47'b0, pdp_v[i]},  {47'b0, m_pdp[i]});
      chk($sformatf("model u%0d.pbd_past", i),  {47'b0, pbdp_v[i]}, {47'b0, m_pbdp[i]});
      chk($sformatf("model u%0d.overflow", i),  {47'b0, ov_v[i]},   {47'b0, e_ov});
      chk($sformatf("model u%0d.underflow", i), {47'b0, un_v[i]},   {47'b0, e_un});
      chk($sformatf("model u%0d.auto_rst", i),  {47'b0, ar_v[i]},   {47'b0, e_ar});
    end
  end

  // Drive inputs, pass one rising edge, then settle 2 units past it.
  task automatic step(input logic [47:0] pv, input logic [47:0] cv, input logic ev);
    p_d = pv;
    c   = cv;
    ce  = ev;
    @(posedge clk);
    #2;
  endtask

  function automatic logic [47:0] rnd48();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[47:0];
  endfunction

  initial begin
    // Reset held for three edges: everything low.
    rst = 1'b0;
    for (int k = 0; k < 3; k++) step(48'h0, 48'h0, 1'b1);
    chk("reset pd",        {44'b0, pd_v},   48'h0);
    chk("reset pbd",       {44'b0, pbd_v},  48'h0);
    chk("reset past",      {44'b0, pdp_v | pbdp_v}, 48'h0);
    chk("reset ov_un",     {44'b0, ov_v | un_v},    48'h0);
    chk("reset auto_rst",  {44'b0, ar_v},   48'h0);

    // First enabled edge after release.
    rst = 1'b1;
    step(48'h0, 48'h0, 1'b1);
    chk("first pd",        {47'b0, pd_v[0]},  48'h1);
    chk("first pd_past",   {47'b0, pdp_v[0]}, 48'h0);
    chk("first overflow",  {47'b0, ov_v[0]},  48'h0);
    chk("full mask pd",    {47'b0, pd_v[3] & pbd_v[3]}, 48'h1);

    // Overflow: leave the match window upward.
    step(48'h0, 48'h0, 1'b1);
    step(48'h4000_0000_0000, 48'h0, 1'b1);
    chk("ovf pd",          {47'b0, pd_v[0]},  48'h0);
    chk("ovf pbd",         {47'b0, pbd_v[0]}, 48'h0);
    chk("ovf overflow",    {47'b0, ov_v[0]},  {47'b0, OV_EN});
    step(48'h4000_0000_0000, 48'h0, 1'b1);
    chk("ovf one cycle",   {47'b0, ov_v[0]},  48'h0);

    // Underflow via dynamic all-ones pattern on instance 2.
    step(48'h0, ONES, 1'b1);
    chk("unf pbd",         {47'b0, pbd_v[2]}, 48'h1);
    step(48'h0, ONES, 1'b1);
    step(48'h4000_0000_0000, ONES, 1'b1);
    chk("unf underflow",   {47'b0, un_v[2]},  {47'b0, OV_EN});
    chk("unf overflow",    {47'b0, ov_v[2]},  48'h0);

    // Masked compare on the low byte only.
    step(48'h1234_5678_9A00, 48'h0, 1'b1);
    chk("mask pd",         {47'b0, pd_v[1]},  48'h1);
    chk("mask pbd",        {47'b0, pbd_v[1]}, 48'h0);
    chk("mask auto_rst",   {47'b0, ar_v[1]},  48'h1);
    step(48'h1234_5678_9AFF, 48'h0, 1'b1);
    chk("maskb pbd",       {47'b0, pbd_v[1]}, 48'h1);
    chk("maskb pd",        {47'b0, pd_v[1]},  48'h0);

    // RESET_MATCH gated by ce.
    step(48'h0, 48'h0, 1'b1);
    chk("ar1 on",          {47'b0, ar_v[1]},  48'h1);
    step(48'h0, 48'h0, 1'b0);
    chk("ar1 ce low",      {47'b0, ar_v[1]},  48'h0);
    chk("ar1 pd held",     {47'b0, pd_v[1]},  48'h1);

    // RESET_NOT_MATCH: one cycle pulse on match then mismatch.
    step(ONES, ONES, 1'b1);
    step(48'h0, ONES, 1'b1);
    chk("ar2 pulse",       {47'b0, ar_v[2]},  {47'b0, OV_EN});
    step(48'h0, ONES, 1'b1);
    chk("ar2 one cycle",   {47'b0, ar_v[2]},  48'h0);
    chk("ar3 illegal",     {47'b0, ar_v[3]},  48'h0);

    // CE hold: flags frozen while p_d and c wander.
    step(48'h0, 48'h0, 1'b1);
    step(48'h0, 48'h0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step(rnd48(), rnd48(), 1'b0);
      chk("hold pd",       {47'b0, pd_v[0]},  48'h1);
      chk("hold pd_past",  {47'b0, pdp_v[0]}, {47'b0, OV_EN});
      chk("hold overflow", {47'b0, ov_v[0]},  48'h0);
    end

    // Asynchronous reset clears immediately, mid-cycle.
    rst = 1'b0;
    #1;
    chk("async reset",     {44'b0, pd_v | pbd_v | pdp_v | pbdp_v}, 48'h0);
    step(48'h0, 48'h0, 1'b1);
    rst = 1'b1;

    // Randomized traffic against the model.
    for (int k = 0; k < 600; k++) begin
      logic [47:0] pv;
      logic [47:0] cv;
      cv = c;
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 2))
          0:       cv = 48'h0;
          1:       cv = ONES;
          default: cv = rnd48();
        endcase
      end
      case ($urandom_range(0, 6))
        0:       pv = 48'h0;
        1:       pv = ONES;
        2:       pv = cv;
        3:       pv = ~cv;
        4:       pv = {rnd48() >> 8, 8'h00};
        5:       pv = {$urandom_range(0, 3) == 0 ? 2'b01 : 2'b10, 46'h0};
        default: pv = rnd48();
      endcase
      rst = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
      step(pv, cv, $urandom_range(0, 4) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
